axi_node_resp_router: RTL and testbench

Response-path router of the AXI node: takes the single response stream (B or R channel) returning from one slave port and steers each beat back to the master port whose index is encoded in the upper ID bits, stripping those bits. It is the return-direction counterpart of the request arbiter, which merges N_MASTER request streams and extends their IDs. The block holds one registered output beat and tracks R bursts. Beats carrying an out-of-range master index are consumed and dropped.

---
 rtl/axi_node_resp_router_pkg.sv | 23 ++
 rtl/axi_node_resp_router_if.sv | 34 +++
 rtl/axi_node_resp_router_reg.sv | 52 +++++
 rtl/axi_node_resp_router.sv | 131 +++++++++++++
 tb/tb_axi_node_resp_router.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_node_resp_router_pkg.sv
// Shared types for the AXI node response router.
// - resp_beat_t   : one response beat {aux, id, last}. Fields are sized to a fixed maximum and
//                   modules use only the low AUX_WIDTH / OID_W bits; unused bits stay zero.
// - burst_state_e : R-burst tracking state.
// - ErrCntWidth   : width of the saturating stray-beat counter.
package axi_node_resp_router_pkg;

    localparam int unsigned ErrCntWidth = 8;
    localparam int unsigned MaxAuxWidth = 64;
    localparam int unsigned MaxIdWidth  = 32;

    typedef struct packed {
        logic [MaxAuxWidth-1:0] aux;
        logic [MaxIdWidth-1:0]  id;
        logic                   last;
    } resp_beat_t;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } burst_state_e;

endpackage

// File: rtl/axi_node_resp_router_if.sv
// Response-path bundle of the AXI node response router.
// inp_*  : single incoming response stream (B or R) from one slave port.
// oup_*  : N_MASTER outgoing streams, flattened (port k at slice k).
// Modports: slave  = router side, master = environment side.
interface axi_node_resp_router_if #(
    parameter int unsigned AUX_WIDTH = 1,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned N_MASTER  = 2
);
    localparam int unsigned IDX_W = $clog2(N_MASTER);
    localparam int unsigned OID_W = ID_WIDTH - IDX_W;

    logic [ID_WIDTH-1:0]           inp_id_i;
    logic [AUX_WIDTH-1:0]          inp_aux_i;
    logic                          inp_last_i;
    logic                          inp_valid_i;
    logic                          inp_ready_o;
    logic [N_MASTER*OID_W-1:0]     oup_id_o;
    logic [N_MASTER*AUX_WIDTH-1:0] oup_aux_o;
    logic [N_MASTER-1:0]           oup_last_o;
    logic [N_MASTER-1:0]           oup_valid_o;
    logic [N_MASTER-1:0]           oup_ready_i;

    modport slave (
        input  inp_id_i, inp_aux_i, inp_last_i, inp_valid_i, oup_ready_i,
        output inp_ready_o, oup_id_o, oup_aux_o, oup_last_o, oup_valid_o
    );

    modport master (
        output inp_id_i, inp_aux_i, inp_last_i, inp_valid_i, oup_ready_i,
        input  inp_ready_o, oup_id_o, oup_aux_o, oup_last_o, oup_valid_o
    );

endinterface

// File: rtl/axi_node_resp_router_reg.sv
// axi_node_resp_reg: single-entry output register with drain-and-refill handshake.
// Ports: clk_i, rst_i (async, active-high); load_i/load_idx_i/load_beat_i write the entry
// (caller only loads when ready_o=1); oup_ready_i per-master ready; ready_o = entry free or
// draining this cycle; beat_o held payload; valid_o one-hot-or-zero per-master valid.
module axi_node_resp_reg
    import axi_node_resp_router_pkg::*;
#(
    parameter int unsigned N_MASTER = 2,
    parameter int unsigned IDX_W    = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [IDX_W-1:0]    load_idx_i,
    input  resp_beat_t          load_beat_i,
    input  logic [N_MASTER-1:0] oup_ready_i,
    output logic                ready_o,
    output resp_beat_t          beat_o,
    output logic [N_MASTER-1:0] valid_o
);

    localparam int unsigned NPad = 1 << IDX_W;

    logic             full_q;
    logic [IDX_W-1:0] idx_q;
    resp_beat_t       beat_q;
    logic [NPad-1:0]  ready_pad;

    // Pad so any idx_q value indexes a real bit; only in-range indices are ever loaded.
    assign ready_pad = NPad'(oup_ready_i);
    assign ready_o   = ~full_q | ready_pad[idx_q];
    assign beat_o    = beat_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            idx_q  <= '0;
            beat_q <= '0;
        end else if (load_i) begin
            full_q <= 1'b1;
            idx_q  <= load_idx_i;
            beat_q <= load_beat_i;
        end else if (full_q && ready_pad[idx_q]) begin
            full_q <= 1'b0;
        end
    end

    for (genvar k = 0; k < N_MASTER; k++) begin : g_valid
        assign valid_o[k] = full_q && (idx_q == IDX_W'(k));
    end

endmodule

// File: rtl/axi_node_resp_router.sv
// axi_node_resp_router: steers each response beat to the master whose index sits in the upper
// ID bits, stripping those bits. Out-of-range indices are consumed and dropped.
// Ports: clk_i, rst_i (async, active-high); bus (slave modport of axi_node_resp_router_if);
// err_o sticky stray flag; err_cnt_o saturating stray count; err_clr_i clears both.
// Build option: AXI_NODE_RESP_ERR_EN enables the stray-beat error flag and counter;
// otherwise err_o/err_cnt_o are tied to 0.
module axi_node_resp_router
    import axi_node_resp_router_pkg::*;
#(
    parameter int unsigned AUX_WIDTH = 1,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned N_MASTER  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    axi_node_resp_router_if.slave  bus,
    output logic                   err_o,
    output logic [ErrCntWidth-1:0] err_cnt_o,
    input  logic                   err_clr_i
);

    localparam int unsigned IDX_W = $clog2(N_MASTER);
    localparam int unsigned OID_W = ID_WIDTH - IDX_W;

    logic [IDX_W-1:0]    idx;
    logic                stray;
    logic                ready;
    logic                accept;
    logic                load;
    resp_beat_t          load_beat;
    resp_beat_t          beat;
    logic [N_MASTER-1:0] valid;
    burst_state_e        state_q;
    logic [ID_WIDTH-1:0] lock_id_q;
    logic                unused_beat;

    assign idx    = bus.inp_id_i[ID_WIDTH-1 -: IDX_W];
    assign stray  = 32'(idx) >= N_MASTER;
    assign accept = bus.inp_valid_i & ready;
    assign load   = accept & ~stray;

    assign bus.inp_ready_o = ready;

    always_comb begin
        load_beat                  = '0;
        load_beat.aux[AUX_WIDTH-1:0] = bus.inp_aux_i;
        load_beat.id[OID_W-1:0]    = bus.inp_id_i[OID_W-1:0];
        load_beat.last             = bus.inp_last_i;
    end

    axi_node_resp_reg #(
        .N_MASTER (N_MASTER),
        .IDX_W    (IDX_W)
    ) u_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load),
        .load_idx_i  (idx),
        .load_beat_i (load_beat),
        .oup_ready_i (bus.oup_ready_i),
        .ready_o     (ready),
        .beat_o      (beat),
        .valid_o     (valid)
    );

    // Payload is broadcast; only valid is steered.
    for (genvar k = 0; k < N_MASTER; k++) begin : g_oup
        assign bus.oup_id_o[k*OID_W +: OID_W]         = beat.id[OID_W-1:0];
        assign bus.oup_aux_o[k*AUX_WIDTH +: AUX_WIDTH] = beat.aux[AUX_WIDTH-1:0];
        assign bus.oup_last_o[k]                      = beat.last;
    end
    assign bus.oup_valid_o = valid;

    // Padding bits of the fixed-width beat struct are never driven out.
    assign unused_beat = ^beat;

    // Burst tracking; stray beats never advance it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            lock_id_q <= '0;
        end else if (load) begin
            unique case (state_q)
                StIdle: begin
                    if (!bus.inp_last_i) begin
                        state_q   <= StBurst;
                        lock_id_q <= bus.inp_id_i;
                    end
                end
                StBurst: begin
                    if (bus.inp_last_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Interleaved R beats are still routed; flag them in simulation only.
    interleave_chk: assert property (@(posedge clk_i) disable iff (rst_i)
        (load && state_q == StBurst) |-> (bus.inp_id_i == lock_id_q))
        else $error("interleaved response id %0h during burst of id %0h",
                    bus.inp_id_i, lock_id_q);

`ifdef AXI_NODE_RESP_ERR_EN
    logic                   err_q;
    logic [ErrCntWidth-1:0] err_cnt_q;

    // Clear wins over a simultaneous stray beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (err_clr_i) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (accept && stray) begin
            err_q <= 1'b1;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign err_o          = 1'b0;
    assign err_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_axi_node_resp_router.sv
module tb_axi_node_resp_router;
    import axi_node_resp_router_pkg::*;

`ifdef AXI_NODE_RESP_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_node_resp_router_if #(.AUX_WIDTH(8), .ID_WIDTH(6), .N_MASTER(4)) b4 ();
    axi_node_resp_router_if #(.AUX_WIDTH(8), .ID_WIDTH(4), .N_MASTER(3)) b3 ();

    logic       err4, err3, clr4, clr3;
    logic [7:0] cnt4, cnt3;

    axi_node_resp_router #(.AUX_WIDTH(8), .ID_WIDTH(6), .N_MASTER(4)) dut4 (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (b4.slave),
        .err_o     (err4),
        .err_cnt_o (cnt4),
        .err_clr_i (clr4)
    );

    axi_node_resp_router #(.AUX_WIDTH(8), .ID_WIDTH(4), .N_MASTER(3)) dut3 (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (b3.slave),
        .err_o     (err3),
        .err_cnt_o (cnt3),
        .err_clr_i (clr3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0] id;
        logic [7:0] aux;
        logic [3:0] exp_valid;
        logic [3:0] exp_id;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] gotq[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  sent;
        int  got;
        logic acc;

        vecs[0] = '{id: 6'b10_0101, aux: 8'hA5, exp_valid: 4'b0100, exp_id: 4'h5};
        vecs[1] = '{id: 6'b00_1111, aux: 8'h3C, exp_valid: 4'b0001, exp_id: 4'hF};
        vecs[2] = '{id: 6'b11_0000, aux: 8'hFF, exp_valid: 4'b1000, exp_id: 4'h0};
        vecs[3] = '{id: 6'b01_1010, aux: 8'h00, exp_valid: 4'b0010, exp_id: 4'hA};

        b4.inp_id_i = '0; b4.inp_aux_i = '0; b4.inp_last_i = 1'b1; b4.inp_valid_i = 1'b0;
        b4.oup_ready_i = 4'hF;
        b3.inp_id_i = '0; b3.inp_aux_i = '0; b3.inp_last_i = 1'b1; b3.inp_valid_i = 1'b0;
        b3.oup_ready_i = 3'b111;
        clr4 = 1'b0; clr3 = 1'b0;

        // Reset values
        #2;
        check("rst_valid", 64'(b4.oup_valid_o), 64'h0);
        check("rst_id", 64'(b4.oup_id_o), 64'h0);
        check("rst_aux", 64'(b4.oup_aux_o), 64'h0);
        check("rst_last", 64'(b4.oup_last_o), 64'h0);
        check("rst_ready", 64'(b4.inp_ready_o), 64'h1);
        check("rst_err", 64'(err4), 64'h0);
        check("rst_cnt", 64'(cnt4), 64'h0);
        check("rst_fsm", 64'(dut4.state_q), 64'(StIdle));
        @(negedge clk);
        rst = 1'b0;

        // Single B beats through the vector table
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b4.inp_id_i = vecs[i].id; b4.inp_aux_i = vecs[i].aux;
            b4.inp_last_i = 1'b1; b4.inp_valid_i = 1'b1;
            #1 check("tbl_inp_ready", 64'(b4.inp_ready_o), 64'h1);
            @(posedge clk); #1;
            b4.inp_valid_i = 1'b0;
            check("tbl_valid", 64'(b4.oup_valid_o), 64'(vecs[i].exp_valid));
            check("tbl_id", 64'(b4.oup_id_o), 64'({4{vecs[i].exp_id}}));
            check("tbl_aux", 64'(b4.oup_aux_o), 64'({4{vecs[i].aux}}));
            check("tbl_last", 64'(b4.oup_last_o), 64'hF);
            check("tbl_fsm", 64'(dut4.state_q), 64'(StIdle));
        end
        @(posedge clk); #1;
        check("tbl_drained", 64'(b4.oup_valid_o), 64'h0);

        // Back-to-back beats to masters 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b4.inp_id_i = {((i % 2) == 0) ? 2'b00 : 2'b01, 4'(i)};
            b4.inp_aux_i = 8'(8'h40 + i); b4.inp_last_i = 1'b1; b4.inp_valid_i = 1'b1;
            #1 check("b2b_inp_ready", 64'(b4.inp_ready_o), 64'h1);
            @(posedge clk); #1;
            check("b2b_valid", 64'(b4.oup_valid_o), ((i % 2) == 0) ? 64'h1 : 64'h2);
            check("b2b_id", 64'(b4.oup_id_o[3:0]), 64'(i));
        end
        b4.inp_valid_i = 1'b0;
        @(posedge clk); #1;

        // R burst of 4 to master 1, ready toggling
        sent = 0; got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            b4.oup_ready_i = ((c % 2) == 0) ? 4'hF : 4'hD;
            b4.inp_valid_i = (sent < 4);
            b4.inp_id_i = 6'b01_0011;
            b4.inp_aux_i = 8'(8'h10 + sent);
            b4.inp_last_i = (sent == 3);
            #1;
            acc = b4.inp_valid_i & b4.inp_ready_o;
            if (b4.oup_valid_o[1] && b4.oup_ready_i[1]) begin
                gotq.push_back(b4.oup_aux_o[15:8]);
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                check("burst_fsm", 64'(dut4.state_q), (sent < 3) ? 64'(StBurst) : 64'(StIdle));
                sent++;
            end
        end
        b4.inp_valid_i = 1'b0; b4.oup_ready_i = 4'hF;
        check("burst_count", 64'(got), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < gotq.size()) check("burst_order", 64'(gotq[k]), 64'(8'h10 + k));
            else check("burst_missing", 64'(k), 64'hFFFF);
        end

        // Held master-0 beat blocks a master-1 beat
        @(negedge clk);
        b4.oup_ready_i = 4'hE;
        b4.inp_id_i = 6'b00_0111; b4.inp_aux_i = 8'h77; b4.inp_last_i = 1'b1;
        b4.inp_valid_i = 1'b1;
        @(negedge clk);
        b4.inp_id_i = 6'b01_0001; b4.inp_aux_i = 8'h11;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_inp_ready", 64'(b4.inp_ready_o), 64'h0);
            check("stall_valid", 64'(b4.oup_valid_o), 64'h1);
            check("stall_aux", 64'(b4.oup_aux_o[7:0]), 64'h77);
            @(negedge clk);
        end
        b4.oup_ready_i = 4'hF;
        #1 check("stall_release_ready", 64'(b4.inp_ready_o), 64'h1);
        @(posedge clk); #1;
        b4.inp_valid_i = 1'b0;
        check("stall_next_valid", 64'(b4.oup_valid_o), 64'h2);
        check("stall_next_aux", 64'(b4.oup_aux_o[15:8]), 64'h11);

        // Reset mid-burst with the register full
        @(negedge clk);
        b4.inp_id_i = 6'b10_0010; b4.inp_aux_i = 8'hA0; b4.inp_last_i = 1'b0;
        b4.inp_valid_i = 1'b1;
        @(negedge clk);
        b4.inp_aux_i = 8'hA1;
        @(posedge clk); #1;
        b4.inp_valid_i = 1'b0; b4.oup_ready_i = 4'hB;
        check("mid_valid", 64'(b4.oup_valid_o), 64'h4);
        check("mid_fsm", 64'(dut4.state_q), 64'(StBurst));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(b4.oup_valid_o), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_post_ready", 64'(b4.inp_ready_o), 64'h1);
        check("mid_post_fsm", 64'(dut4.state_q), 64'(StIdle));
        check("mid_post_valid", 64'(b4.oup_valid_o), 64'h0);
        b4.oup_ready_i = 4'hF; b4.inp_last_i = 1'b1;

        // Stray beats on the 3-master instance
        @(negedge clk);
        b3.inp_id_i = 4'b11_01; b3.inp_aux_i = 8'hEE; b3.inp_valid_i = 1'b1;
        #1 check("stray_inp_ready", 64'(b3.inp_ready_o), 64'h1);
        @(posedge clk); #1;
        check("stray_valid", 64'(b3.oup_valid_o), 64'h0);
        check("stray_err", 64'(err3), ErrEn ? 64'h1 : 64'h0);
        check("stray_cnt1", 64'(cnt3), ErrEn ? 64'd1 : 64'd0);
        for (int i = 1; i < 300; i++) @(posedge clk);
        #1;
        b3.inp_valid_i = 1'b0;
        check("stray_sat", 64'(cnt3), ErrEn ? 64'd255 : 64'd0);
        check("stray_sat_valid", 64'(b3.oup_valid_o), 64'h0);
        @(negedge clk);
        clr3 = 1'b1; b3.inp_valid_i = 1'b1;
        @(posedge clk); #1;
        clr3 = 1'b0; b3.inp_valid_i = 1'b0;
        check("clr_wins_err", 64'(err3), 64'h0);
        check("clr_wins_cnt", 64'(cnt3), 64'h0);
        @(negedge clk);
        b3.inp_valid_i = 1'b1;
        @(posedge clk); #1;
        b3.inp_valid_i = 1'b0;
        check("stray_again", 64'(cnt3), ErrEn ? 64'd1 : 64'd0);
        @(negedge clk);
        clr3 = 1'b1;
        @(posedge clk); #1;
        clr3 = 1'b0;
        check("clr_err", 64'(err3), 64'h0);
        check("clr_cnt", 64'(cnt3), 64'h0);

        // In-range beat on the 3-master instance
        @(negedge clk);
        b3.inp_id_i = 4'b10_11; b3.inp_aux_i = 8'h5A; b3.inp_valid_i = 1'b1;
        @(posedge clk); #1;
        b3.inp_valid_i = 1'b0;
        check("n3_valid", 64'(b3.oup_valid_o), 64'h4);
        check("n3_id", 64'(b3.oup_id_o[1:0]), 64'h3);
        check("n3_aux", 64'(b3.oup_aux_o[23:16]), 64'h5A);
        check("n3_err", 64'(err3), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
